// File: rtl/ctr_wt_pkg.sv
// Shared definitions for the ctr_wt counter bank.
//   ctr_mode_e  : per-channel counting mode (2-bit field on the mode bus)
//   mode_decode : folds the reserved encoding onto HOLD_UP
package ctr_wt_pkg;

  typedef enum logic [1:0] {
    WRAP_UP = 2'b00,
    HOLD_UP = 2'b01,
    WRAP_DN = 2'b10,
    RSVD    = 2'b11
  } ctr_mode_e;

  function automatic ctr_mode_e mode_decode(input logic [1:0] raw);
    ctr_mode_e m;
    m = ctr_mode_e'(raw);
    if (m == RSVD) m = HOLD_UP;
    return m;
  endfunction

endpackage

// File: rtl/ctr_wt_lane.sv
// One channel of the limit-counter bank.
//   clk, rst_n : clock, asynchronous active-low reset
//   en, clr    : count enable, synchronous clear (clr has priority)
//   mode       : ctr_mode_e encoding, reserved value behaves as HOLD_UP
//   N          : limit (terminal value up, reload value down)
//   a          : registered count
//   tc         : registered one-cycle terminal-count pulse
//   done       : sticky flag, set on entry to HOLD_UP terminal state
module ctr_wt_lane
  import ctr_wt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] a,
  output logic             tc,
  output logic             done
);

  ctr_mode_e        md;
  logic             term;
  logic [WIDTH-1:0] a_q, a_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  // Up modes use >= so a limit lowered below the current count
  // terminates on the next enabled edge instead of overshooting.
  always_comb begin
    md   = mode_decode(mode);
    term = (md == WRAP_DN) ? (a_q == '0) : (a_q >= N);
  end

  always_comb begin
    a_d    = a_q;
    tc_d   = 1'b0;
    done_d = done_q;
    if (clr) begin
      a_d    = (md == WRAP_DN) ? N : '0;
      done_d = 1'b0;
    end else if (en) begin
      if (!term) begin
        a_d = (md == WRAP_DN) ? (a_q - WIDTH'(1)) : (a_q + WIDTH'(1));
      end else begin
        unique case (md)
          WRAP_UP: begin
            a_d  = '0;
            tc_d = 1'b1;
          end
          WRAP_DN: begin
            a_d  = N;
            tc_d = 1'b1;
          end
          default: begin
            // Hold at the limit; pulse only on the first terminal edge.
            tc_d   = ~done_q;
            done_d = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      tc_q   <= tc_d;
      done_q <= done_d;
    end
  end

  assign a    = a_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule

// File: rtl/ctr_wt_multi.sv
// Bank of NCH independent limit counters (see ctr_wt_lane).
//   clk, rst_n : clock, asynchronous active-low reset
//   en, clr    : per-channel enable / synchronous clear (NCH bits)
//   mode       : per-channel mode, ch k = mode[2k+1:2k]
//   N          : per-channel limit, ch k = N[WIDTH*k +: WIDTH]
//   a          : per-channel registered count
//   tc         : per-channel terminal-count pulse
//   done       : per-channel sticky done (HOLD_UP only)
//   all_done   : AND of all done bits, combinational
module ctr_wt_multi
  import ctr_wt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NCH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       clr,
  input  logic [2*NCH-1:0]     mode,
  input  logic [WIDTH*NCH-1:0] N,
  output logic [WIDTH*NCH-1:0] a,
  output logic [NCH-1:0]       tc,
  output logic [NCH-1:0]       done,
  output logic                 all_done
);

  for (genvar k = 0; k < NCH; k++) begin : lane
    ctr_wt_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en[k]),
      .clr   (clr[k]),
      .mode  (mode[2*k +: 2]),
      .N     (N[WIDTH*k +: WIDTH]),
      .a     (a[WIDTH*k +: WIDTH]),
      .tc    (tc[k]),
      .done  (done[k])
    );
  end

  assign all_done = &done;

endmodule

// File: tb/tb_ctr_wt_multi.sv
module tb_ctr_wt_multi;
  localparam int WIDTH = 4;
  localparam int NCH   = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       en;
  logic [NCH-1:0]       clr;
  logic [2*NCH-1:0]     mode;
  logic [WIDTH*NCH-1:0] N;
  logic [WIDTH*NCH-1:0] a;
  logic [NCH-1:0]       tc;
  logic [NCH-1:0]       done;
  logic                 all_done;

  always #5 clk = ~clk;

  ctr_wt_multi #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .mode     (mode),
    .N        (N),
    .a        (a),
    .tc       (tc),
    .done     (done),
    .all_done (all_done)
  );

  int nvec = 0;
  int nerr = 0;
  int m_a[NCH];
  int m_tc[NCH];
  int m_done[NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int ch_a(input int k);
    return int'(a[WIDTH*k +: WIDTH]);
  endfunction

  // Reference: count values as plain integers, limit taken from N each edge.
  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_a[k] = 0; m_tc[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NCH; k++) begin
      int md, lim;
      md  = int'(mode[2*k +: 2]);
      lim = int'(N[WIDTH*k +: WIDTH]);
      if (md == 3) md = 1;
      m_tc[k] = 0;
      if (clr[k]) begin
        m_a[k]    = (md == 2) ? lim : 0;
        m_done[k] = 0;
      end else if (en[k]) begin
        if (md == 2) begin
          if (m_a[k] == 0) begin m_a[k] = lim; m_tc[k] = 1; end
          else m_a[k] = m_a[k] - 1;
        end else if (m_a[k] >= lim) begin
          if (md == 0) begin m_a[k] = 0; m_tc[k] = 1; end
          else begin m_tc[k] = (m_done[k] == 0) ? 1 : 0; m_done[k] = 1; end
        end else begin
          m_a[k] = m_a[k] + 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int alld;
    alld = 1;
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("%s a[%0d]", tag, k), 32'(a[WIDTH*k +: WIDTH]), 32'(m_a[k]));
      chk($sformatf("%s tc[%0d]", tag, k), 32'(tc[k]), 32'(m_tc[k]));
      chk($sformatf("%s done[%0d]", tag, k), 32'(done[k]), 32'(m_done[k]));
      if (m_done[k] == 0) alld = 0;
    end
    chk($sformatf("%s all_done", tag), 32'(all_done), 32'(alld));
  endtask

  // Inputs are changed only just after a step returns (posedge + 1).
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_ch(input int k, input logic [1:0] md, input logic [WIDTH-1:0] n);
    mode[2*k +: 2]     = md;
    N[WIDTH*k +: WIDTH] = n;
  endtask

  initial begin : main
    int exp_a4[6];
    int exp_tc4[6];
    int guard;
    exp_a4  = '{4, 3, 2, 1, 0, 4};
    exp_tc4 = '{1, 0, 0, 0, 0, 1};

    rst_n = 1'b0; en = '0; clr = '0; mode = '0; N = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // T1: asynchronous reset in the middle of a count
    set_ch(0, 2'b00, 4'd15);
    en = 4'b0001;
    repeat (7) step("t1");
    chk("t1 a0 before reset", 32'(ch_a(0)), 32'd7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t1 async reset");
    en = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // T2: WRAP_UP, N=5
    set_ch(0, 2'b00, 4'd5);
    en = 4'b0001; clr = 4'b0001;
    step("t2 clr");
    clr = '0;
    for (int i = 1; i <= 12; i++) begin
      step("t2");
      chk($sformatf("t2 a0 i%0d", i), 32'(ch_a(0)), 32'(i % 6));
      chk($sformatf("t2 tc0 i%0d", i), 32'(tc[0]), (i % 6 == 0) ? 32'd1 : 32'd0);
    end

    // T3: HOLD_UP, N=3, then clear
    set_ch(1, 2'b01, 4'd3);
    en = 4'b0010; clr = 4'b0010;
    step("t3 clr");
    clr = '0;
    for (int i = 1; i <= 6; i++) begin
      step("t3");
      if (i == 4) begin
        chk("t3 a1 hold", 32'(ch_a(1)), 32'd3);
        chk("t3 tc1 entry", 32'(tc[1]), 32'd1);
        chk("t3 done1 set", 32'(done[1]), 32'd1);
      end
      if (i == 6) begin
        chk("t3 a1 still", 32'(ch_a(1)), 32'd3);
        chk("t3 tc1 once", 32'(tc[1]), 32'd0);
        chk("t3 done1 sticky", 32'(done[1]), 32'd1);
      end
    end
    clr = 4'b0010;
    step("t3 clr2");
    clr = '0;
    chk("t3 a1 cleared", 32'(ch_a(1)), 32'd0);
    chk("t3 done1 cleared", 32'(done[1]), 32'd0);

    // T4: WRAP_DN, N=4, starting from a=0
    set_ch(2, 2'b10, 4'd4);
    en = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      step("t4");
      chk($sformatf("t4 a2 i%0d", i), 32'(ch_a(2)), 32'(exp_a4[i]));
      chk($sformatf("t4 tc2 i%0d", i), 32'(tc[2]), 32'(exp_tc4[i]));
    end

    // T5: limit lowered below the count, then N=0
    set_ch(0, 2'b00, 4'd15);
    en = 4'b0001; clr = 4'b0001;
    step("t5 clr");
    clr = '0;
    repeat (9) step("t5");
    chk("t5 a0 mid", 32'(ch_a(0)), 32'd9);
    set_ch(0, 2'b00, 4'd6);
    step("t5 lower");
    chk("t5 a0 wrap", 32'(ch_a(0)), 32'd0);
    chk("t5 tc0 wrap", 32'(tc[0]), 32'd1);
    set_ch(0, 2'b00, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step("t5 n0");
      chk("t5 n0 a0", 32'(ch_a(0)), 32'd0);
      chk("t5 n0 tc0", 32'(tc[0]), 32'd1);
    end

    // T6: all HOLD_UP, random enables, then clr+en collision
    for (int k = 0; k < NCH; k++) set_ch(k, 2'b01, WIDTH'(k + 2));
    clr = '1; en = '0;
    step("t6 clr");
    clr = '0;
    guard = 0;
    while (!(m_done[0] && m_done[1] && m_done[2] && m_done[3]) && guard < 200) begin
      en = NCH'($urandom);
      step("t6");
      guard++;
    end
    chk("t6 all_done reached", 32'(all_done), 32'd1);
    en = '1; clr = 4'b0001;
    step("t6 clr wins");
    clr = '0;
    chk("t6 done0 cleared", 32'(done[0]), 32'd0);
    chk("t6 all_done dropped", 32'(all_done), 32'd0);

    // Randomized traffic across all channels
    for (int i = 0; i < 2000; i++) begin
      en = NCH'($urandom);
      for (int k = 0; k < NCH; k++) begin
        clr[k] = ($urandom_range(15) == 0);
        if ($urandom_range(31) == 0) mode[2*k +: 2] = 2'($urandom);
        if ($urandom_range(31) == 0) N[WIDTH*k +: WIDTH] = WIDTH'($urandom);
      end
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
